// File: rtl/uart_pkg.sv
// Purpose: shared constants and state encoding for the uart transmit/receive pair.
// Latency: n/a (definitions only).
// Backpressure: n/a.
// Contents: UART_DATA_BITS, UART_CLKS_PER_BIT (shared divider default), uart_state_t,
//           parity helper. UART_RX_PARITY_EN selects the parity frame in uart_rx.
package uart_pkg;

   localparam int UART_DATA_BITS    = 8;
   // Single source for the bit divider so tx and rx defaults cannot drift apart.
   localparam int UART_CLKS_PER_BIT = 4;

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      START  = 3'd1,
      DATA   = 3'd2,
      PARITY = 3'd3,
      STOP   = 3'd4,
      BREAK  = 3'd5
   } uart_state_t;

   // Even parity: data bits plus parity bit must XOR to zero.
   function automatic logic parity_bad(input logic [7:0] data, input logic par);
      return ^{data, par};
   endfunction

endpackage

// File: rtl/uart_sync2.sv
// Purpose: two-flop synchronizer for one asynchronous input bit.
// Latency: 2 clk cycles from d to q.
// Backpressure: none; free-running.
// Ports: clk, n_rst (async active-low), d (async input), q (synchronized output).
//        Both flops reset to RST_VAL so an idle-high line reads as idle out of reset.
module uart_sync2 #(
   parameter logic RST_VAL = 1'b1
) (
   input  logic clk,
   input  logic n_rst,
   input  logic d,
   output logic q
);

   logic meta_q, meta_d;
   logic sync_q, sync_d;

   always_comb begin
      meta_d = d;
      sync_d = meta_q;
   end

   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) begin
         meta_q <= RST_VAL;
         sync_q <= RST_VAL;
      end else begin
         meta_q <= meta_d;
         sync_q <= sync_d;
      end
   end

   assign q = sync_q;

endmodule

// File: rtl/uart_rx.sv
// Purpose: 8N1 (optionally 8E1) asynchronous serial receiver, LSB first, idle-high line.
// Latency: valid 3 + CLKS_PER_BIT/2 + 9*CLKS_PER_BIT clocks after rx first goes low (+CLKS_PER_BIT with parity).
// Backpressure: none; valid/frame_err are single-cycle strobes, the consumer must take dout on valid.
// Ports: clk, n_rst (async active-low), rx (async serial in), dout (last good byte),
//        valid (dout updated), frame_err (stop bit low), busy (frame in progress),
//        parity_err (only when UART_RX_PARITY_EN is defined: parity bit wrong, byte dropped).
module uart_rx
   import uart_pkg::*;
#(
   parameter int CLKS_PER_BIT = UART_CLKS_PER_BIT,
   parameter int DATA_BITS    = UART_DATA_BITS
) (
   input  logic       clk,
   input  logic       n_rst,
   input  logic       rx,
   output logic [7:0] dout,
   output logic       valid,
   output logic       frame_err,
`ifdef UART_RX_PARITY_EN
   output logic       parity_err,
`endif
   output logic       busy
);

   localparam int          CW        = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
   localparam logic [CW-1:0] CNT_HALF = CW'(CLKS_PER_BIT / 2 - 1);
   localparam logic [CW-1:0] CNT_LAST = CW'(CLKS_PER_BIT - 1);
   localparam logic [2:0]  BIT_LAST  = 3'(DATA_BITS - 1);

   logic rx_s;

   uart_sync2 #(.RST_VAL(1'b1)) u_sync (
      .clk   (clk),
      .n_rst (n_rst),
      .d     (rx),
      .q     (rx_s)
   );

   uart_state_t   state_q, state_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic [2:0]    bit_cnt_q, bit_cnt_d;
   logic [7:0]    shift_q, shift_d;
   logic [7:0]    dout_q, dout_d;
   logic          valid_q, valid_d;
   logic          frame_err_q, frame_err_d;
   logic          busy_q, busy_d;
`ifdef UART_RX_PARITY_EN
   logic          par_q, par_d;
   logic          parity_err_q, parity_err_d;
`endif

   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      bit_cnt_d   = bit_cnt_q;
      shift_d     = shift_q;
      dout_d      = dout_q;
      valid_d     = 1'b0;
      frame_err_d = 1'b0;
`ifdef UART_RX_PARITY_EN
      par_d        = par_q;
      parity_err_d = 1'b0;
`endif

      case (state_q)
         IDLE: begin
            if (!rx_s) begin
               state_d = START;
               cnt_d   = '0;
            end
         end

         START: begin
            // Re-check the line half a bit in; a short low pulse is a glitch.
            if (cnt_q == CNT_HALF) begin
               cnt_d = '0;
               if (!rx_s) begin
                  state_d   = DATA;
                  bit_cnt_d = '0;
               end else begin
                  state_d = IDLE;
               end
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end

         DATA: begin
            // cnt restarted at mid-start-bit, so every wrap lands mid-bit.
            if (cnt_q == CNT_LAST) begin
               cnt_d   = '0;
               shift_d = {rx_s, shift_q[7:1]};
               if (bit_cnt_q == BIT_LAST) begin
`ifdef UART_RX_PARITY_EN
                  state_d = PARITY;
`else
                  state_d = STOP;
`endif
               end else begin
                  bit_cnt_d = bit_cnt_q + 3'd1;
               end
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end

`ifdef UART_RX_PARITY_EN
         PARITY: begin
            if (cnt_q == CNT_LAST) begin
               cnt_d   = '0;
               par_d   = rx_s;
               state_d = STOP;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
`endif

         STOP: begin
            // Decide at mid-stop-bit and return to IDLE immediately so a start
            // bit that directly follows the stop bit is not missed.
            if (cnt_q == CNT_LAST) begin
               cnt_d = '0;
               if (!rx_s) begin
                  frame_err_d = 1'b1;
                  state_d     = BREAK;
               end
`ifdef UART_RX_PARITY_EN
               else if (parity_bad(shift_q, par_q)) begin
                  parity_err_d = 1'b1;
                  state_d      = IDLE;
               end
`endif
               else begin
                  dout_d  = shift_q;
                  valid_d = 1'b1;
                  state_d = IDLE;
               end
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end

         BREAK: begin
            // Wait out a held-low line so it reports only one frame error.
            if (rx_s) begin
               state_d = IDLE;
            end
         end

         default: begin
            state_d = IDLE;
         end
      endcase

      busy_d = (state_d != IDLE);
   end

   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) begin
         state_q      <= IDLE;
         cnt_q        <= '0;
         bit_cnt_q    <= '0;
         shift_q      <= '0;
         dout_q       <= '0;
         valid_q      <= 1'b0;
         frame_err_q  <= 1'b0;
         busy_q       <= 1'b0;
`ifdef UART_RX_PARITY_EN
         par_q        <= 1'b0;
         parity_err_q <= 1'b0;
`endif
      end else begin
         state_q      <= state_d;
         cnt_q        <= cnt_d;
         bit_cnt_q    <= bit_cnt_d;
         shift_q      <= shift_d;
         dout_q       <= dout_d;
         valid_q      <= valid_d;
         frame_err_q  <= frame_err_d;
         busy_q       <= busy_d;
`ifdef UART_RX_PARITY_EN
         par_q        <= par_d;
         parity_err_q <= parity_err_d;
`endif
      end
   end

   assign dout      = dout_q;
   assign valid     = valid_q;
   assign frame_err = frame_err_q;
   assign busy      = busy_q;
`ifdef UART_RX_PARITY_EN
   assign parity_err = parity_err_q;
`endif

endmodule
